// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus arbiter and the reservation
// stations that consume its broadcasts.
package cdb_arbiter_pkg;

   // Arbiter FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_BCAST = 2'd2
   } cdb_state_t;

   // Station tag width; tag value 0 means "no producer"
   localparam int CDB_TAG_W = 3;
   localparam logic [CDB_TAG_W-1:0] TAG_NONE = 3'd0;

   // Execution cycle counter width (latency is at most 7)
   localparam int CNT_W = 3;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin selector: first requester at or after ptr+1,
// wrapping past the top index back to 0.
module rr_picker #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic             any_o,
   output logic [N-1:0]     oh_o,
   output logic [IDX_W-1:0] idx_o
);

   // Scan N positions starting one past the pointer, keep the first hit
   always_comb begin
      int j;
      j     = 0;
      any_o = 1'b0;
      oh_o  = {N{1'b0}};
      idx_o = {IDX_W{1'b0}};
      for (int k = 1; k <= N; k++) begin
         j = (int'(ptr_i) + k) % N;
         if (!any_o && req_i[j]) begin
            any_o   = 1'b1;
            oh_o[j] = 1'b1;
            idx_o   = IDX_W'(j);
         end else begin
            any_o = any_o;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one ready reservation station round-robin,
// models the functional-unit latency, then broadcasts tag/value on the CDB
// and holds the broadcast while the consumer stalls.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_RS      = 4,
   parameter int DATA_W      = 16,
   parameter int TAG_W       = CDB_TAG_W,
   parameter int EXEC_CYCLES = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_RS-1:0]        ready_i,
   input  logic [NUM_RS*DATA_W-1:0] result_in_i,
   input  logic                     cdb_stall_i,
   output logic [NUM_RS-1:0]        grant_o,
   output logic                     cdb_valid_o,
   output logic [TAG_W-1:0]         cdb_tag_o,
   output logic [DATA_W-1:0]        cdb_value_o,
   output logic                     fu_busy_o
);

   localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);
   localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NUM_RS - 1);

   cdb_state_t          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [NUM_RS-1:0]   oh_q, oh_d;
   logic [DATA_W-1:0]   val_q, val_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic                valid_q, valid_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic [DATA_W-1:0]   value_q, value_d;
   logic                busy_q, busy_d;

   logic                pick_any;
   logic [NUM_RS-1:0]   pick_oh;
   logic [IDX_W-1:0]    pick_idx;

   rr_picker #(
      .N     (NUM_RS),
      .IDX_W (IDX_W)
   ) u_picker (
      .req_i (ready_i),
      .ptr_i (ptr_q),
      .any_o (pick_any),
      .oh_o  (pick_oh),
      .idx_o (pick_idx)
   );

   // Next-state logic: select in IDLE, count latency in EXEC, hold in BCAST
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      oh_d    = oh_q;
      val_d   = val_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               state_d = ST_EXEC;
               cnt_d   = CNT_LOAD;
               idx_d   = pick_idx;
               oh_d    = pick_oh;
               val_d   = result_in_i[pick_idx*DATA_W +: DATA_W];
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (cnt_q == {CNT_W{1'b0}}) begin
               state_d = ST_BCAST;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_BCAST: begin
            if (cdb_stall_i) begin
               state_d = ST_BCAST;
            end else begin
               ptr_d   = idx_q;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered outputs follow the next state so they line up with it
   always_comb begin
      valid_d = (state_d == ST_BCAST);
      busy_d  = (state_d != ST_IDLE);
      if (valid_d) begin
         tag_d   = TAG_W'(idx_d) + TAG_W'(1);
         value_d = val_d;
      end else begin
         tag_d   = TAG_W'(TAG_NONE);
         value_d = {DATA_W{1'b0}};
      end
   end

   // Grant pulses only in the cycle the broadcast is accepted
   always_comb begin
      if ((state_q == ST_BCAST) && !cdb_stall_i) begin
         grant_o = oh_q;
      end else begin
         grant_o = {NUM_RS{1'b0}};
      end
   end

   // State and output registers; reset aborts any operation in flight
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         idx_q   <= {IDX_W{1'b0}};
         oh_q    <= {NUM_RS{1'b0}};
         val_q   <= {DATA_W{1'b0}};
         ptr_q   <= PTR_INIT;
         valid_q <= 1'b0;
         tag_q   <= {TAG_W{1'b0}};
         value_q <= {DATA_W{1'b0}};
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         oh_q    <= oh_d;
         val_q   <= val_d;
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         tag_q   <= tag_d;
         value_q <= value_d;
         busy_q  <= busy_d;
      end
   end

   assign cdb_valid_o = valid_q;
   assign cdb_tag_o   = tag_q;
   assign cdb_value_o = value_q;
   assign fu_busy_o   = busy_q;

endmodule
